// File: rtl/cfu_pkg.sv
// Shared definitions for the CFU lane engine: op encodings, FSM states and the
// lane-count derivation used by the engine and by anything that drives it.
package cfu_pkg;

   typedef enum logic [2:0] {
      OP_SUM   = 3'd0,
      OP_LSWAP = 3'd1,
      OP_BREV  = 3'd2,
      OP_DOT   = 3'd3,
      OP_MAC   = 3'd4,
      OP_ACCRD = 3'd5,
      OP_RSV6  = 3'd6,
      OP_RSV7  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic int n_lanes(input int lane_w);
      return 32 / lane_w;
   endfunction

endpackage

// File: rtl/cfu_lane_engine_if.sv
// Command/response handshake bundle of the CFU lane engine; the engine is the
// slave, the CPU side (or a testbench) is the master.
interface cfu_lane_engine_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0;
   logic [31:0] cmd_payload_inputs_1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_payload_outputs_0;

   modport master (
      output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
             cmd_payload_inputs_1, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_payload_outputs_0
   );

   modport slave (
      input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
             cmd_payload_inputs_1, rsp_ready,
      output cmd_ready, rsp_valid, rsp_payload_outputs_0
   );

endinterface

// File: rtl/cfu_lane_mac.sv
// One lane step of the dot product: signed LANE_W x LANE_W multiply, product
// sign-extended to 32 bits and added to the running sum (wrap-around).
module cfu_lane_mac #(
   parameter int LANE_W = 8
) (
   input  logic [LANE_W-1:0] a_lane,
   input  logic [LANE_W-1:0] b_lane,
   input  logic [31:0]       acc_in,
   output logic [31:0]       acc_out
);

   logic signed [2*LANE_W-1:0] prod_w;

   assign prod_w  = $signed(a_lane) * $signed(b_lane);
   assign acc_out = acc_in + 32'(prod_w);

endmodule

// File: rtl/cfu_lane_engine.sv
// CFU lane engine: SIMD lane ops on two 32-bit operands; DOT/MAC iterate one lane
// per clock. Define CFU_ACCUM_EN to build the MAC accumulator (ops 4 and 5).
module cfu_lane_engine
   import cfu_pkg::*;
#(
   parameter int LANE_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   cfu_lane_engine_if.slave   bus
);

   localparam int N_LANES = n_lanes(LANE_W);
   localparam int IDX_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);

   state_e            state_reg, state_next;
   logic [31:0]       a_reg, a_next;
   logic [31:0]       b_reg, b_next;
   logic [31:0]       dot_reg, dot_next;
   logic [31:0]       rsp_data_reg, rsp_data_next;
   logic              rsp_valid_reg, rsp_valid_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;

   logic              cmd_ready_w;
   logic              accept_w;
   op_e               cmd_op_w;
   logic [31:0]       sum_w, lswap_w, brev_w, single_w, mac_out_w;
   logic [LANE_W-1:0] lane_a_w [N_LANES];
   logic [LANE_W-1:0] lane_b_w [N_LANES];
   logic [LANE_W-1:0] sel_a_w, sel_b_w;
   logic              unused_fid_bits;

   assign cmd_op_w        = op_e'(bus.cmd_payload_function_id[2:0]);
   assign unused_fid_bits = ^bus.cmd_payload_function_id[9:3];

   // Single-cycle results are computed straight from the command bus.
   genvar gi;
   generate
      for (gi = 0; gi < N_LANES; gi++) begin : g_lane
         assign lane_a_w[gi] = bus.cmd_payload_inputs_0[gi*LANE_W +: LANE_W];
         assign lane_b_w[gi] = bus.cmd_payload_inputs_1[gi*LANE_W +: LANE_W];
         assign lswap_w[gi*LANE_W +: LANE_W] =
            bus.cmd_payload_inputs_0[(N_LANES-1-gi)*LANE_W +: LANE_W];
      end
      for (gi = 0; gi < 32; gi++) begin : g_brev
         assign brev_w[gi] = bus.cmd_payload_inputs_0[31-gi];
      end
   endgenerate

   always_comb begin
      sum_w = '0;
      for (int i = 0; i < N_LANES; i++) begin
         sum_w = sum_w + 32'(lane_a_w[i]) + 32'(lane_b_w[i]);
      end
   end

`ifdef CFU_ACCUM_EN
   logic [31:0] acc_reg, acc_next;
   logic        mac_reg, mac_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_reg <= '0;
         mac_reg <= 1'b0;
      end else begin
         acc_reg <= acc_next;
         mac_reg <= mac_next;
      end
   end
`endif

   always_comb begin
      single_w = '0;
      case (cmd_op_w)
         OP_SUM:   single_w = sum_w;
         OP_LSWAP: single_w = lswap_w;
         OP_BREV:  single_w = brev_w;
`ifdef CFU_ACCUM_EN
         OP_ACCRD: single_w = acc_reg;
`endif
         default:  single_w = '0;
      endcase
   end

   assign sel_a_w = a_reg[int'(idx_reg)*LANE_W +: LANE_W];
   assign sel_b_w = b_reg[int'(idx_reg)*LANE_W +: LANE_W];

   cfu_lane_mac #(
      .LANE_W (LANE_W)
   ) u_lane_mac (
      .a_lane  (sel_a_w),
      .b_lane  (sel_b_w),
      .acc_in  (dot_reg),
      .acc_out (mac_out_w)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         dot_reg       <= '0;
         rsp_data_reg  <= '0;
         rsp_valid_reg <= 1'b0;
         idx_reg       <= '0;
      end else begin
         state_reg     <= state_next;
         a_reg         <= a_next;
         b_reg         <= b_next;
         dot_reg       <= dot_next;
         rsp_data_reg  <= rsp_data_next;
         rsp_valid_reg <= rsp_valid_next;
         idx_reg       <= idx_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      a_next         = a_reg;
      b_next         = b_reg;
      dot_next       = dot_reg;
      rsp_data_next  = rsp_data_reg;
      rsp_valid_next = rsp_valid_reg;
      idx_next       = idx_reg;
      cmd_ready_w    = 1'b0;
`ifdef CFU_ACCUM_EN
      acc_next       = acc_reg;
      mac_next       = mac_reg;
`endif

      case (state_reg)
         IDLE: cmd_ready_w = 1'b1;
         BUSY: begin
            dot_next = mac_out_w;
            idx_next = idx_reg + 1'b1;
            if (idx_reg == LAST_IDX) begin
               state_next     = RESP;
               rsp_valid_next = 1'b1;
               idx_next       = '0;
               rsp_data_next  = mac_out_w;
`ifdef CFU_ACCUM_EN
               // The accumulator moves only here, on the edge into RESP.
               if (mac_reg) begin
                  acc_next      = acc_reg + mac_out_w;
                  rsp_data_next = acc_reg + mac_out_w;
               end
`endif
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               cmd_ready_w    = 1'b1;
               state_next     = IDLE;
               rsp_valid_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase

      // A new command overrides the RESP->IDLE return, giving back-to-back issue.
      accept_w = bus.cmd_valid && cmd_ready_w;
      if (accept_w) begin
         if (cmd_op_w == OP_DOT || cmd_op_w == OP_MAC) begin
            state_next     = BUSY;
            rsp_valid_next = 1'b0;
            a_next         = bus.cmd_payload_inputs_0;
            b_next         = bus.cmd_payload_inputs_1;
            dot_next       = '0;
            idx_next       = '0;
`ifdef CFU_ACCUM_EN
            mac_next       = (cmd_op_w == OP_MAC);
`endif
         end else begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_data_next  = single_w;
`ifdef CFU_ACCUM_EN
            if (cmd_op_w == OP_ACCRD) begin
               acc_next = '0;
            end
`endif
         end
      end
   end

   assign bus.cmd_ready             = cmd_ready_w;
   assign bus.rsp_valid             = rsp_valid_reg;
   assign bus.rsp_payload_outputs_0 = rsp_data_reg;

endmodule

// File: tb/tb_cfu_lane_engine.sv
// Self-checking bench for cfu_lane_engine: vector table, directed corner cases
// and random ops against an arithmetic reference model (LANE_W 8, plus a 16-bit instance).
module tb_cfu_lane_engine;

   localparam int LANE_W = 8;
   localparam int NL     = 32 / LANE_W;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cfu_lane_engine_if bus ();
   cfu_lane_engine_if bus16 ();

   cfu_lane_engine #(.LANE_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   cfu_lane_engine #(.LANE_W(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16.slave)
   );

   int vectors     = 0;
   int miscompares = 0;
   logic [31:0] model_acc;

   typedef struct {
      logic [9:0]  fid;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   function automatic logic [31:0] ref_dot(input logic [31:0] a, input logic [31:0] b);
      int s;
      s = 0;
      for (int i = 0; i < NL; i++) begin
         logic signed [LANE_W-1:0] la;
         logic signed [LANE_W-1:0] lb;
         la = a[i*LANE_W +: LANE_W];
         lb = b[i*LANE_W +: LANE_W];
         s = s + int'(la) * int'(lb);
      end
      return 32'(s);
   endfunction

   function automatic logic [31:0] ref_single(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [31:0] r;
      r = '0;
      case (op)
         3'd0: for (int i = 0; i < NL; i++)
                  r = r + 32'(a[i*LANE_W +: LANE_W]) + 32'(b[i*LANE_W +: LANE_W]);
         3'd1: for (int i = 0; i < NL; i++)
                  r[i*LANE_W +: LANE_W] = a[(NL-1-i)*LANE_W +: LANE_W];
         3'd2: for (int i = 0; i < 32; i++) r[i] = a[31-i];
         default: r = '0;
      endcase
      return r;
   endfunction

   // One full transaction: offer, wait for accept, scramble inputs, wait for result, take it.
   task automatic issue(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int low_cnt);
      int n;
      @(negedge clk);
      bus.cmd_valid               = 1'b1;
      bus.cmd_payload_function_id = fid;
      bus.cmd_payload_inputs_0    = a;
      bus.cmd_payload_inputs_1    = b;
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: cmd_ready 0 for %0d cycles, required 1", n);
      end
      @(posedge clk);
      #1;
      bus.cmd_valid               = 1'b0;
      bus.cmd_payload_inputs_0    = $urandom;
      bus.cmd_payload_inputs_1    = $urandom;
      bus.cmd_payload_function_id = 10'($urandom);
      lat     = 0;
      low_cnt = 0;
      while (lat < 50) begin
         @(negedge clk);
         lat++;
         if (bus.rsp_valid === 1'b1) break;
         if (bus.cmd_ready === 1'b0) low_cnt++;
      end
      res = bus.rsp_payload_outputs_0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] res, held, exp;
      int          lat, low, n, cnt;
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [31:0] a16 [2];
      logic [31:0] b16 [2];
      logic [31:0] e16 [2];
      logic [9:0]  f16 [2];
      int          l16 [2];

      tbl[0] = '{10'd0,   32'h01020304, 32'h10203040, 32'h000000AA, 1};
      tbl[1] = '{10'd1,   32'h11223344, 32'h00000000, 32'h44332211, 1};
      tbl[2] = '{10'd2,   32'h00000001, 32'hDEADBEEF, 32'h80000000, 1};
      tbl[3] = '{10'd3,   32'hFF020304, 32'h02020202, 32'h00000010, NL + 1};
      tbl[4] = '{10'd6,   32'hCAFEF00D, 32'h12345678, 32'h00000000, 1};
      tbl[5] = '{10'h3FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1};
      tbl[6] = '{10'h3F8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h000007F8, 1};
      tbl[7] = '{10'd3,   32'h80808080, 32'h80808080, 32'h00010000, NL + 1};
      tbl[8] = '{10'd3,   32'h7F7F7F7F, 32'h80808080, 32'hFFFF0200, NL + 1};
      tbl[9] = '{10'd2,   32'h12345678, 32'h00000000, 32'h1E6A2C48, 1};

      a16 = '{32'h11223344, 32'hFFFF0003};
      b16 = '{32'h00000000, 32'h00020005};
      e16 = '{32'h33441122, 32'h0000000D};
      f16 = '{10'd1, 10'd3};
      l16 = '{1, 3};

      bus.cmd_valid = 1'b0;  bus.rsp_ready = 1'b0;
      bus.cmd_payload_function_id = '0;
      bus.cmd_payload_inputs_0 = '0;  bus.cmd_payload_inputs_1 = '0;
      bus16.cmd_valid = 1'b0;  bus16.rsp_ready = 1'b1;
      bus16.cmd_payload_function_id = '0;
      bus16.cmd_payload_inputs_0 = '0;  bus16.cmd_payload_inputs_1 = '0;
      reset = 1'b1;
      model_acc = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset_payload", bus.rsp_payload_outputs_0, 32'd0);
      reset = 1'b0;
      #1;
      check("post_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      // Vector table
      for (int i = 0; i < 10; i++) begin
         issue(tbl[i].fid, tbl[i].a, tbl[i].b, res, lat, low);
         check($sformatf("vec%0d_result", i), res, tbl[i].exp);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
         check($sformatf("vec%0d_busy_ready_low", i), 32'(low), 32'(tbl[i].lat - 1));
      end

      // 16-bit lane instance: LSWAP and a two-lane DOT
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus16.cmd_valid = 1'b1;
         bus16.cmd_payload_function_id = f16[i];
         bus16.cmd_payload_inputs_0 = a16[i];
         bus16.cmd_payload_inputs_1 = b16[i];
         @(posedge clk);
         #1;
         bus16.cmd_valid = 1'b0;
         bus16.cmd_payload_inputs_0 = $urandom;
         n = 0;
         while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus16.rsp_valid === 1'b1) break;
         end
         check($sformatf("lw16_vec%0d_result", i), bus16.rsp_payload_outputs_0, e16[i]);
         check($sformatf("lw16_vec%0d_latency", i), 32'(n), 32'(l16[i]));
      end

      // MAC / ACCRD sequence
      for (int i = 0; i < 4; i++) begin
         op = (i < 2) ? 3'd4 : 3'd5;
`ifdef CFU_ACCUM_EN
         exp = (i == 0) ? 32'h10 : (i == 1) ? 32'h20 : (i == 2) ? 32'h20 : 32'h0;
`else
         exp = (i < 2) ? 32'h10 : 32'h0;
`endif
         issue({7'd0, op}, 32'hFF020304, 32'h02020202, res, lat, low);
         check($sformatf("macseq%0d_result", i), res, exp);
         check($sformatf("macseq%0d_latency", i), 32'(lat), (op == 3'd4) ? 32'(NL + 1) : 32'd1);
      end

      // Backpressure on a MAC result, then ACCRD chained into the completing cycle
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_payload_function_id = 10'd4;
      bus.cmd_payload_inputs_0 = 32'hFF020304;
      bus.cmd_payload_inputs_1 = 32'h02020202;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_payload_inputs_0 = $urandom;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (bus.rsp_valid === 1'b1) break;
      end
      held = bus.rsp_payload_outputs_0;
      check("bp_mac_result", held, 32'h10);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("bp_hold%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
         check($sformatf("bp_hold%0d_payload", k), bus.rsp_payload_outputs_0, 32'h10);
      end
      bus.rsp_ready = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_payload_function_id = 10'd5;
      #1;
      check("bp_chain_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_chain_valid", 32'(bus.rsp_valid), 32'd1);
`ifdef CFU_ACCUM_EN
      check("bp_chain_accrd", bus.rsp_payload_outputs_0, 32'h10);
`else
      check("bp_chain_accrd", bus.rsp_payload_outputs_0, 32'h0);
`endif
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;

      // Reset asserted mid-BUSY
      issue(10'd4, 32'hFF020304, 32'h02020202, res, lat, low);
      check("prereset_mac", res, 32'h10);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_payload_function_id = 10'd4;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("busy_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
      reset = 1'b1;
      #1;
      check("midbusy_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("midbusy_reset_payload", bus.rsp_payload_outputs_0, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midbusy_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0) cnt++;
      end
      check("no_rsp_after_reset", 32'(cnt), 32'd0);
      issue(10'd5, 32'h0, 32'h0, res, lat, low);
      check("acc_cleared_by_reset", res, 32'h0);
      model_acc = '0;

      // Random ops against the reference model
      for (int i = 0; i < 80; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if (op == 3'd3) begin
            exp = ref_dot(a, b);
         end else if (op == 3'd4) begin
`ifdef CFU_ACCUM_EN
            model_acc = model_acc + ref_dot(a, b);
            exp = model_acc;
`else
            exp = ref_dot(a, b);
`endif
         end else if (op == 3'd5) begin
`ifdef CFU_ACCUM_EN
            exp = model_acc;
            model_acc = '0;
`else
            exp = '0;
`endif
         end else begin
            exp = ref_single(op, a, b);
         end
         issue({7'($urandom), op}, a, b, res, lat, low);
         check($sformatf("rand%0d_op%0d_result", i, op), res, exp);
         check($sformatf("rand%0d_op%0d_latency", i, op), 32'(lat),
               (op == 3'd3 || op == 3'd4) ? 32'(NL + 1) : 32'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
